// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Instruction fetch unit with a prefetch FIFO feeding the instruction
//   register. Owns the fetch PC, issues one word fetch at a time over a
//   req/ack handshake, buffers returned {pc, word} pairs and lets decode pop
//   them with valid/ready. A redirect flushes the queue and restarts fetch;
//   a fetch already in flight is completed and its data dropped.
//
// Ports
//   CLK          clock, all state updates on posedge
//   RESET        synchronous, active-high reset
//   mem_req      fetch request (registered)
//   mem_addr     word-aligned fetch address (registered)
//   mem_ack      memory returns mem_rdata this cycle (only while mem_req=1)
//   mem_rdata    fetched instruction word
//   redirect     one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   ins_valid    queue head holds an instruction
//   ins_out      head instruction word, 0 when empty
//   ins_pc       head instruction byte address, 0 when empty
//   ins_ready    decode accepts the head this cycle
//
// FSM
//   state   | meaning
//   IDLE    | no fetch in flight; start one when a FIFO slot is free
//   WAIT    | fetch of fetch_pc in flight, data will be pushed on ack
//   DISCARD | fetch of a pre-redirect address in flight, data dropped on ack

module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      mem_addr_nxt;
  logic [31:0]      fifo_pc   [DEPTH];
  logic [31:0]      fifo_word [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic             push;
  logic             pop;

  // A redirect kills both the same-cycle push and pop.
  assign push = (state == WAIT) && mem_ack && !redirect;
  assign pop  = ins_valid && ins_ready && !redirect;

  assign ins_valid = (count != '0);
  assign ins_out   = ins_valid ? fifo_word[rd_ptr] : 32'h0;
  assign ins_pc    = ins_valid ? fifo_pc[rd_ptr]   : 32'h0;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    count_after  = count;
    mem_addr_nxt = mem_addr;

    if (push && !pop) begin
      count_after = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_after = count - CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (!redirect && (count < FULL_CNT)) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          // Only keep requesting while a slot stays reserved for the next word.
          state_nxt    = (count_after < FULL_CNT) ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        // The dropped ack completes the old handshake even if a new redirect
        // arrives in the same cycle; that redirect only moves fetch_pc.
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_nxt = redirect_pc & ~32'h3;
    end

    // In DISCARD the bus keeps the in-flight address, which is the address
    // already on mem_addr when the redirect arrived.
    if (state_nxt != DISCARD) begin
      mem_addr_nxt = fetch_pc_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      fetch_pc <= START_PC;
      mem_addr <= START_PC;
      mem_req  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      mem_addr <= mem_addr_nxt;
      mem_req  <= (state_nxt != IDLE);
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count_after;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_word[wr_ptr] <= mem_rdata;
    end
  end

  // A request is only issued with a slot free, so a push can never hit a full queue.
  push_never_full: assert property (@(posedge CLK) disable iff (RESET)
    !(push && (count == FULL_CNT)));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
//   Directed scenarios followed by randomized traffic. A reference model
//   keeps the expected instruction queue as a plain queue of {pc, word}, the
//   next expected fetch address, and whether an in-flight fetch is being
//   thrown away after a redirect.

module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_out     (ins_out),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] disc_addr;
  bit          discarding;
  bit          outstanding;
  int          stall_run;

  task automatic model_reset();
    q.delete();
    m_pc        = 32'h0;
    disc_addr   = 32'h0;
    discarding  = 1'b0;
    outstanding = 1'b0;
    stall_run   = 0;
  endtask

  task automatic model_check();
    chk("ins_valid", 32'(ins_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("ins_pc", ins_pc, q[0].pc);
      chk("ins_out", ins_out, q[0].word);
    end else begin
      chk("ins_pc_empty", ins_pc, 32'h0);
      chk("ins_out_empty", ins_out, 32'h0);
    end
    chk("mem_addr", mem_addr, discarding ? disc_addr : m_pc);
    if (outstanding) chk("req_held", 32'(mem_req), 32'h1);
    if (mem_req && !discarding) chk("slot_reserved", 32'(q.size() < DEPTH), 32'h1);
    if (!mem_req && (q.size() < DEPTH)) stall_run++;
    else stall_run = 0;
    chk("no_stall", 32'(stall_run <= 1), 32'h1);
  endtask

  task automatic model_update(input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic rd, input logic [31:0] rpc);
    bit   ack_ev;
    bit   pop_ev;
    ent_t e;
    ack_ev = mem_req && ack;
    pop_ev = (q.size() != 0) && rdy;
    if (pop_ev) void'(q.pop_front());
    if (ack_ev && discarding) begin
      discarding = 1'b0;
    end else if (ack_ev) begin
      e.pc   = m_pc;
      e.word = rdata;
      q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    outstanding = mem_req && !ack;
    if (rd) begin
      q.delete();
      if (mem_req && !ack && !discarding) begin
        discarding = 1'b1;
        disc_addr  = m_pc;
      end
      m_pc      = rpc & ~32'h3;
      stall_run = 0;
    end
  endtask

  // Called at a negedge: check, drive this cycle's inputs, advance the model.
  task automatic cycle(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic rd, input logic [31:0] rpc);
    model_check();
    mem_ack     = ack;
    mem_rdata   = rdata;
    ins_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    model_update(ack, rdata, rdy, rd, rpc);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    mem_ack   = 1'b0;
    ins_ready = 1'b0;
    redirect  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'h0);
    chk("rst_ins_out", ins_out, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h0);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic wait_req(input int lim, input logic rdy);
    int n;
    n = 0;
    while (!mem_req && n < lim) begin
      cycle(1'b0, 32'h0, rdy, 1'b0, 32'h0);
      n++;
    end
    chk("req_timeout", 32'(mem_req), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acks;
    int   lat;
    bit   done_rd;
    bit   seen;
    bit   saw_new;
    logic a;
    logic r;

    @(negedge CLK);

    // Zero-wait memory, decode always ready.
    do_reset();
    wait_req(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_req", 32'(mem_req), 32'h1);
      chk("t1_addr", mem_addr, 32'(i * 4));
      if (i > 0) begin
        chk("t1_pc", ins_pc, 32'((i - 1) * 4));
        chk("t1_word", ins_out, 32'h100 + 32'((i - 1) * 4));
      end
      cycle(1'b1, mem_addr + 32'h100, 1'b1, 1'b0, 32'h0);
    end

    // Decode stalled: queue fills, then one pop frees one slot.
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) acks++;
      cycle(1'b1, mem_addr + 32'h100, 1'b0, 1'b0, 32'h0);
    end
    chk("t2_acks", 32'(acks), 32'd4);
    chk("t2_req_off", 32'(mem_req), 32'h0);
    chk("t2_head", ins_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    wait_req(3, 1'b0);
    chk("t2_addr", mem_addr, 32'h10);
    chk("t2_head_after_pop", ins_pc, 32'h4);

    // 3-cycle memory, redirect during the fetch of addr 8.
    do_reset();
    lat = 0; done_rd = 0; seen = 0; saw_new = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      a = 1'b0;
      r = 1'b0;
      if (done_rd && ins_valid) begin
        chk("t3_first_pc", ins_pc, 32'h200);
        seen = 1;
      end
      if (done_rd && mem_req && mem_addr != 32'h8 && !saw_new) begin
        chk("t3_next_addr", mem_addr, 32'h200);
        saw_new = 1;
      end
      if (mem_req) begin
        lat++;
        if (lat == 3) begin
          a   = 1'b1;
          lat = 0;
        end
      end
      if (mem_req && mem_addr == 32'h8 && !done_rd && lat == 1) begin
        r       = 1'b1;
        done_rd = 1;
      end
      cycle(a, mem_addr + 32'h100, 1'b1, r, 32'h203);
    end
    chk("t3_seen", 32'(seen), 32'h1);

    // Redirect in the same cycle as the ack for addr 4 and a pop.
    do_reset();
    wait_req(3, 1'b1);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    chk("t4_addr", mem_addr, 32'h4);
    chk("t4_valid", 32'(ins_valid), 32'h1);
    cycle(1'b1, 32'h104, 1'b1, 1'b1, 32'h40);
    chk("t4_empty", 32'(ins_valid), 32'h0);
    chk("t4_next_addr", mem_addr, 32'h40);
    wait_req(3, 1'b1);
    chk("t4_req_addr", mem_addr, 32'h40);

    // count = DEPTH-1 with simultaneous push and pop, across pointer wrap.
    do_reset();
    wait_req(3, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 32'hA000 + 32'(i), 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      chk("t5_req", 32'(mem_req), 32'h1);
      chk("t5_head", ins_pc, 32'(i * 4));
      cycle(1'b1, 32'hB000 + 32'(i), 1'b1, 1'b0, 32'h0);
    end

    // Reset while a dropped fetch is still in flight.
    do_reset();
    wait_req(3, 1'b0);
    cycle(1'b1, 32'h1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h2, 1'b0, 1'b0, 32'h0);
    chk("t6_count2", ins_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t6_discard_req", 32'(mem_req), 32'h1);
    chk("t6_discard_addr", mem_addr, 32'h8);
    do_reset();
    wait_req(3, 1'b1);
    chk("t6_restart", mem_addr, 32'h0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 29) == 0), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
